// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_arbiter.
// The arbiter uses the slave view; the bench (requesters plus memory model) uses master.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic          err;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata, mem_ready,
    output gnt0, gnt1, done0, done1, err, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata, mem_ready,
    input  gnt0, gnt1, done0, done1, err, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared instruction/data memory.
// Requester 0 is the CPU, requester 1 the DMA; all outputs are registered.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          pick1_s;

  // On a tie the requester that did not own the previous access wins.
  assign pick1_s = bus.req1 & (~bus.req0 | ~last_owner_q);

  // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d     = S_ACCESS;
          owner_d     = pick1_s;
          gnt0_d      = ~pick1_s;
          gnt1_d      = pick1_s;
          mem_en_d    = 1'b1;
          mem_we_d    = pick1_s ? bus.we1    : bus.we0;
          mem_addr_d  = pick1_s ? bus.addr1  : bus.addr0;
          mem_wdata_d = pick1_s ? bus.wdata1 : bus.wdata0;
          cnt_d       = {CW{1'b0}};
        end else begin
          gnt0_d   = 1'b0;
          gnt1_d   = 1'b0;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          state_d  = S_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          err_d    = 1'b0;
          if (!mem_we_q) begin
            rdata_d = bus.mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        state_d      = S_IDLE;
        last_owner_d = owner_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= {CW{1'b0}};
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= {DW{1'b0}};
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requesters and memory are driven from one sequence,
// outputs are checked on the falling edge against hand-computed values.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and check the mutual-exclusion invariants
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_b("gnt_excl", bus.gnt0 & bus.gnt1, 1'b0);
    check_b("done_excl", bus.done0 & bus.done1, 1'b0);
  endtask

  logic [3:0] tie_exp [8];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 32'h0; bus.wdata0 = 32'h0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 32'h0; bus.wdata1 = 32'h0;
    bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;
    tie_exp = '{4'b1000, 4'b1010, 4'b0000, 4'b0100, 4'b0101, 4'b0000, 4'b1000, 4'b1010};

    // reset state
    cyc();
    cyc();
    check_b("rst_gnt0", bus.gnt0, 1'b0);
    check_b("rst_gnt1", bus.gnt1, 1'b0);
    check_b("rst_done0", bus.done0, 1'b0);
    check_b("rst_err", bus.err, 1'b0);
    check_b("rst_mem_en", bus.mem_en, 1'b0);
    check_b("rst_mem_we", bus.mem_we, 1'b0);
    check_w("rst_mem_addr", bus.mem_addr, 32'h0);
    check_w("rst_rdata", bus.rdata, 32'h0);
    reset = 1'b0;

    // 1: single CPU read, zero wait
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h100;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    cyc();
    bus.req0 = 1'b0;
    check_b("t1_mem_en", bus.mem_en, 1'b1);
    check_w("t1_mem_addr", bus.mem_addr, 32'h100);
    check_b("t1_gnt0", bus.gnt0, 1'b1);
    check_b("t1_gnt1", bus.gnt1, 1'b0);
    check_b("t1_done0_early", bus.done0, 1'b0);
    cyc();
    check_b("t1_done0", bus.done0, 1'b1);
    check_b("t1_err", bus.err, 1'b0);
    check_w("t1_rdata", bus.rdata, 32'hDEADBEEF);
    check_b("t1_mem_en_off", bus.mem_en, 1'b0);
    check_b("t1_gnt0_resp", bus.gnt0, 1'b1);
    cyc();
    check_b("t1_done0_off", bus.done0, 1'b0);
    check_b("t1_gnt0_idle", bus.gnt0, 1'b0);
    bus.mem_ready = 1'b0;

    // 2: tie after reset, strict alternation CPU, DMA, CPU
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h30;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check_w("t2_gnt_done", {28'h0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, {28'h0, tie_exp[i]});
      if (i == 3) check_w("t2_dma_addr", bus.mem_addr, 32'h30);
      if (i == 6) check_w("t2_cpu_addr", bus.mem_addr, 32'h10);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc();
    check_w("t2_idle", {28'h0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'h0);
    bus.mem_ready = 1'b0;

    // 3: DMA write with three wait states
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h20; bus.wdata1 = 32'h55;
    bus.mem_rdata = 32'hBAD;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.req1 = 1'b0;
      check_b("t3_mem_en", bus.mem_en, 1'b1);
      check_b("t3_mem_we", bus.mem_we, 1'b1);
      check_w("t3_wdata", bus.mem_wdata, 32'h55);
      check_w("t3_addr", bus.mem_addr, 32'h20);
      check_b("t3_gnt1", bus.gnt1, 1'b1);
      if (i == 3) bus.mem_ready = 1'b1;
    end
    cyc();
    bus.mem_ready = 1'b0;
    check_b("t3_done1", bus.done1, 1'b1);
    check_b("t3_err", bus.err, 1'b0);
    check_w("t3_rdata_kept", bus.rdata, 32'h11);
    check_b("t3_mem_en_off", bus.mem_en, 1'b0);
    cyc();

    // 4a: timeout, memory never ready
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h44;
    for (int i = 0; i < 15; i++) begin
      cyc();
      bus.req0 = 1'b0;
      check_b("t4_mem_en", bus.mem_en, 1'b1);
      check_b("t4_no_done", bus.done0, 1'b0);
    end
    cyc();
    check_b("t4_done0", bus.done0, 1'b1);
    check_b("t4_err", bus.err, 1'b1);
    check_w("t4_rdata_kept", bus.rdata, 32'h11);
    check_b("t4_mem_en_off", bus.mem_en, 1'b0);
    cyc();
    check_b("t4_err_off", bus.err, 1'b0);

    // 4b: ready in the final allowed cycle counts as success
    bus.req0 = 1'b1; bus.mem_rdata = 32'hCAFE0001;
    for (int i = 0; i < 15; i++) begin
      cyc();
      bus.req0 = 1'b0;
      check_b("t4b_mem_en", bus.mem_en, 1'b1);
      if (i == 14) bus.mem_ready = 1'b1;
    end
    cyc();
    bus.mem_ready = 1'b0;
    check_b("t4b_done0", bus.done0, 1'b1);
    check_b("t4b_err", bus.err, 1'b0);
    check_w("t4b_rdata", bus.rdata, 32'hCAFE0001);
    cyc();

    // 5: address change mid-access is ignored
    bus.req0 = 1'b1; bus.addr0 = 32'h40;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.req0 = 1'b0; bus.addr0 = 32'h80;
      check_w("t5_addr", bus.mem_addr, 32'h40);
      if (i == 2) bus.mem_ready = 1'b1;
    end
    cyc();
    bus.mem_ready = 1'b0;
    check_b("t5_done0", bus.done0, 1'b1);
    check_w("t5_addr_resp", bus.mem_addr, 32'h40);
    cyc();

    // 6: reset in ACCESS, then a tie must go to the CPU
    bus.req0 = 1'b1; bus.addr0 = 32'h60;
    cyc();
    bus.req0 = 1'b0;
    check_b("t6_mem_en", bus.mem_en, 1'b1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_b("t6_mem_en_rst", bus.mem_en, 1'b0);
    check_b("t6_gnt0_rst", bus.gnt0, 1'b0);
    check_b("t6_done0_rst", bus.done0, 1'b0);
    check_w("t6_rdata_rst", bus.rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_b("t6_no_done", bus.done0, 1'b0);
      check_b("t6_idle_en", bus.mem_en, 1'b0);
    end
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr1 = 32'h70; bus.we1 = 1'b0;
    bus.mem_ready = 1'b1;
    cyc();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check_b("t6_tie_gnt0", bus.gnt0, 1'b1);
    check_b("t6_tie_gnt1", bus.gnt1, 1'b0);
    check_w("t6_tie_addr", bus.mem_addr, 32'h60);
    cyc();
    bus.mem_ready = 1'b0;
    check_b("t6_tie_done0", bus.done0, 1'b1);
    check_b("t6_tie_done1", bus.done1, 1'b0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
